bcd_scan_display: RTL



---
 rtl/bcd_scan_display.sv | 116 +++++++++++
 1 files changed

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver for an MM:SS BCD timer.
// Digits are snapshotted once per scan frame; the separator blinks on the ML decimal point.
module bcd_scan_display #(
  parameter int CLK_DIV      = 4,
  parameter int BLINK_FRAMES = 2,
  parameter int LZB          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] BCD_SL,
  input  logic [3:0] BCD_SH,
  input  logic [3:0] BCD_ML,
  input  logic [3:0] BCD_MH,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  // Non-BCD codes show a dash so corrupt inputs are visible rather than misleading.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             colon_q, colon_d;
  logic [15:0]      snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  logic             tick;
  logic             frame_wrap;
  logic [3:0]       cur_digit;
  logic             blank;

  always_comb begin
    tick       = (div_q == DIV_LAST);
    frame_wrap = tick && (idx_q == 2'd3);
    div_d      = tick ? '0 : div_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    snap_d     = frame_wrap ? {BCD_MH, BCD_ML, BCD_SH, BCD_SL} : snap_q;
    frm_d      = frm_q;
    colon_d    = colon_q;
    if (frame_wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        colon_d = ~colon_q;
      end else begin
        frm_d   = frm_q + 1'b1;
      end
    end
  end

  // Output stage: decode from the snapshot only, never the live inputs.
  always_comb begin
    case (idx_q)
      2'd0:    cur_digit = snap_q[3:0];
      2'd1:    cur_digit = snap_q[7:4];
      2'd2:    cur_digit = snap_q[11:8];
      default: cur_digit = snap_q[15:12];
    endcase
    blank = !en || ((LZB != 0) && (idx_q == 2'd3) && (cur_digit == 4'd0));
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h00 : seg_decode(cur_digit);
    dp_d  = colon_q && (idx_q == 2'd2) && en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      idx_q   <= 2'd0;
      frm_q   <= '0;
      colon_q <= 1'b0;
      snap_q  <= 16'h0000;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      an_q    <= 4'b1111;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      colon_q <= colon_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
